sr_latch_bank_sequencer: RTL
============================

Name: sr_latch_bank_sequencer

Overview:
- Controller that sequences writes into a bank of N gated SR latches (sr_latch_w_en instances).
- Accepts one set/reset/toggle request at a time over a valid/ready handshake.
- Drives per-latch S/R/E with a fixed setup → enable-pulse → hold timeline, never producing S=R=1 at any latch.
- After each request, checks the latch Q feedback and reports done/err.

Parameters:
- N, 4, number of latches in the bank.
- IDX_W, 2, width of the latch index; N ≤ 2^IDX_W.
- SETUP_CYC, 1, cycles S/R are stable before E rises (≥1).
- PULSE_CYC, 2, cycles E is held high (≥1).
- HOLD_CYC, 1, cycles S/R are held after E falls (≥1).

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-high reset.
- req_valid  in  1  request present.
- req_ready  out  1  sequencer can accept; high only in IDLE.
- req_op  in  2  00 NOP, 01 SET, 10 RESET, 11 TOGGLE.
- req_idx  in  IDX_W  target latch.
- q_in  in  N  Q outputs of the latch bank.
- s_out  out  N  per-latch S.
- r_out  out  N  per-latch R.
- e_out  out  N  per-latch E.
- busy  out  1  high in any state except IDLE.
- done  out  1  one-cycle completion strobe.
- err  out  1  check result; valid only while done=1.

Behaviour:
- Clock and reset: one clock domain. reset is asynchronous, active-high.
- Reset values while reset is high:
  - State = IDLE.
  - s_out, r_out, e_out, busy, done, err all 0.
  - req_ready = 1 (decoded from IDLE).
- Outputs are registered or decoded from registered state only. No combinational path from req_* to s/r/e.
- States: IDLE, SETUP, PULSE, HOLD, CHECK. A single down-counter provides the timing in SETUP, PULSE and HOLD.
- Acceptance: at a rising edge where req_valid & req_ready, the block captures op, idx, and (for TOGGLE) q_in[idx].
  - SET: expected = 1. RESET: expected = 0.
  - TOGGLE: resolves to RESET if the captured Q = 1, otherwise SET.
- NOP, or idx ≥ N:
  - Go directly to CHECK. No s/r/e activity.
  - err = 1 for idx ≥ N; err = 0 for a valid-index NOP.
- SET/RESET transitions:
  - IDLE → SETUP (SETUP_CYC cycles): only s_out[idx] (SET) or only r_out[idx] (RESET) is high; e_out = 0.
  - → PULSE (PULSE_CYC cycles): e_out[idx] = 1; s/r unchanged.
  - → HOLD (HOLD_CYC cycles): e_out = 0; s/r unchanged.
  - → CHECK (1 cycle): s/r/e all 0; done = 1; err = (q_in[idx] ≠ expected), sampled at entry to CHECK.
  - → IDLE.
- Latency: done is high in the cycle starting SETUP_CYC+PULSE_CYC+HOLD_CYC edges after the acceptance edge (4 with defaults). A NOP reports done one edge after acceptance.
- Back-to-back: a new request can be accepted in the first IDLE cycle after CHECK. Throughput is one request per SETUP_CYC+PULSE_CYC+HOLD_CYC+2 cycles.
- Invariants, checked every cycle:
  - s_out & r_out == 0.
  - e_out is zero or one-hot.
  - e_out[i] = 1 implies exactly one of s_out[i] and r_out[i] is 1.
  - s/r never change while any e_out bit is high.
- Request inputs while busy: req_valid and req_op/req_idx changes are ignored; the captured values are used.
- Reset mid-operation (any state): outputs clear immediately, asynchronously. E drops with S/R, so the latch keeps whatever value it had already taken. After reset, the sequencer returns to IDLE with req_ready = 1 and no done.
- q_in changing during SETUP/PULSE/HOLD does not affect sequencing. It is sampled only at the TOGGLE capture and at CHECK.

Test Plan:
- Reset held, then released with req_valid=0 → s/r/e=0, busy=0, req_ready=1, done never pulses.
- SET idx=2, latch model Q2 initially 0 → s_out=0100 for 1 cycle with e_out=0, then e_out=0100 for 2 cycles, then 1 hold cycle. done=1 and err=0 exactly 4 edges after acceptance; Q2 = 1.
- TOGGLE idx=2 with Q2=1 → r_out=0100 (s_out stays 0). done=1, err=0, Q2 = 0. Repeat TOGGLE → SET path, Q2 = 1.
- SET idx=1 with latch model forced stuck at 0 → done=1, err=1. Next request is accepted in the following cycle.
- Assert reset during PULSE of RESET idx=0 → e_out/r_out go 0 without waiting for a clock edge, state returns to IDLE, no done. A following SET idx=0 completes normally.
- Random request stream over 200 requests, including NOP, with req_valid held during busy → invariants hold every cycle, and there is exactly one done per accepted request.

Source files
------------

// File: rtl/sr_latch_bank_sequencer_if.sv
// Request/completion interface of the SR latch bank sequencer.
//   req_valid/req_ready : one-at-a-time request handshake
//   req_op              : 00 NOP, 01 SET, 10 RESET, 11 TOGGLE
//   req_idx             : target latch index
//   busy                : sequencer is not idle
//   done                : one-cycle completion strobe
//   err                 : Q check result, meaningful only while done=1
interface sr_latch_bank_sequencer_if #(
    parameter int IDX_W = 2
);
    logic             req_valid;
    logic             req_ready;
    logic [1:0]       req_op;
    logic [IDX_W-1:0] req_idx;
    logic             busy;
    logic             done;
    logic             err;

    modport master (
        output req_valid, req_op, req_idx,
        input  req_ready, busy, done, err
    );

    modport slave (
        input  req_valid, req_op, req_idx,
        output req_ready, busy, done, err
    );
endinterface

// File: rtl/sr_latch_bank_sequencer.sv
// Sequences set/reset/toggle writes into a bank of N gated SR latches.
// Each write drives S or R for the target latch, pulses E, holds S/R, then
// compares the latch Q feedback against the intended value.
// Ports:
//   clk    : rising-edge clock
//   reset  : asynchronous, active-high reset
//   req    : request/completion interface (slave side)
//   q_in   : Q outputs of the latch bank
//   s_out  : per-latch S
//   r_out  : per-latch R
//   e_out  : per-latch E (gate)
//
// state | meaning
// IDLE  | waiting for a request, req_ready=1
// SETUP | S or R of the target latch stable, E low
// PULSE | E of the target latch high
// HOLD  | E low again, S or R still held
// CHECK | done strobe, err reports Q mismatch / bad index
module sr_latch_bank_sequencer #(
    parameter int N         = 4,
    parameter int IDX_W     = 2,
    parameter int SETUP_CYC = 1,
    parameter int PULSE_CYC = 2,
    parameter int HOLD_CYC  = 1
) (
    input  logic                          clk,
    input  logic                          reset,
    sr_latch_bank_sequencer_if.slave      req,
    input  logic [N-1:0]                  q_in,
    output logic [N-1:0]                  s_out,
    output logic [N-1:0]                  r_out,
    output logic [N-1:0]                  e_out
);

    localparam int MAX_CYC_A = (SETUP_CYC > PULSE_CYC) ? SETUP_CYC : PULSE_CYC;
    localparam int MAX_CYC   = (MAX_CYC_A > HOLD_CYC) ? MAX_CYC_A : HOLD_CYC;
    localparam int CNT_W     = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;
    localparam logic [IDX_W:0] N_LIM = (IDX_W + 1)'(N);

    localparam logic [1:0] OP_NOP    = 2'b00;
    localparam logic [1:0] OP_SET    = 2'b01;
    localparam logic [1:0] OP_TOGGLE = 2'b11;

    typedef enum logic [2:0] {IDLE, SETUP, PULSE, HOLD, CHECK} state_t;

    state_t           state, state_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic [IDX_W-1:0] idx_r, idx_nxt;
    // set_r selects S (1) or R (0) and doubles as the expected Q value.
    logic             set_r, set_nxt;
    logic             err_r, err_nxt;
    logic             idx_ok;
    logic             q_sel;
    logic [N-1:0]     onehot;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
            cnt   <= '0;
            idx_r <= '0;
            set_r <= 1'b0;
            err_r <= 1'b0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            idx_r <= idx_nxt;
            set_r <= set_nxt;
            err_r <= err_nxt;
        end
    end

    assign idx_ok = {1'b0, req.req_idx} < N_LIM;
    assign q_sel  = q_in[req.req_idx];

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        idx_nxt   = idx_r;
        set_nxt   = set_r;
        err_nxt   = err_r;
        case (state)
            IDLE: begin
                if (req.req_valid) begin
                    idx_nxt = req.req_idx;
                    if (!idx_ok) begin
                        state_nxt = CHECK;
                        err_nxt   = 1'b1;
                    end else if (req.req_op == OP_NOP) begin
                        state_nxt = CHECK;
                        err_nxt   = 1'b0;
                    end else begin
                        // TOGGLE resolves against Q captured at acceptance.
                        set_nxt   = (req.req_op == OP_SET) ||
                                    ((req.req_op == OP_TOGGLE) && !q_sel);
                        state_nxt = SETUP;
                        cnt_nxt   = CNT_W'(SETUP_CYC - 1);
                        err_nxt   = 1'b0;
                    end
                end
            end
            SETUP: begin
                if (cnt == '0) begin
                    state_nxt = PULSE;
                    cnt_nxt   = CNT_W'(PULSE_CYC - 1);
                end else begin
                    cnt_nxt = cnt - 1'b1;
                end
            end
            PULSE: begin
                if (cnt == '0) begin
                    state_nxt = HOLD;
                    cnt_nxt   = CNT_W'(HOLD_CYC - 1);
                end else begin
                    cnt_nxt = cnt - 1'b1;
                end
            end
            HOLD: begin
                if (cnt == '0) begin
                    state_nxt = CHECK;
                    err_nxt   = (q_in[idx_r] != set_r);
                end else begin
                    cnt_nxt = cnt - 1'b1;
                end
            end
            CHECK: state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // All latch controls decode from registered state so reset clears them
    // immediately, and S/R/E share one one-hot so S=R=1 cannot occur.
    always_comb begin
        onehot = '0;
        if (state == SETUP || state == PULSE || state == HOLD) begin
            onehot = N'(1) << idx_r;
        end
    end

    assign s_out         = set_r ? onehot : '0;
    assign r_out         = set_r ? '0 : onehot;
    assign e_out         = (state == PULSE) ? onehot : '0;
    assign req.req_ready = (state == IDLE);
    assign req.busy      = (state != IDLE);
    assign req.done      = (state == CHECK);
    assign req.err       = (state == CHECK) && err_r;

endmodule
